// File: rtl/ysyx_23060201_pkg.sv
// Shared constants for the NPC general-purpose register file.
package ysyx_23060201_pkg;

    localparam int GPR_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;
    localparam logic [GPR_ADDR_WIDTH-1:0] X0 = '0;

endpackage

// File: rtl/ysyx_23060201_gpr_rport.sv
// One combinational GPR read port: write-back bypass, x0 masking and scoreboard busy flag.
module ysyx_23060201_gpr_rport #(
    parameter int AW    = ysyx_23060201_pkg::GPR_ADDR_WIDTH,
    parameter int DW    = ysyx_23060201_pkg::DATA_WIDTH,
    parameter int NW    = 2,
    parameter int CNT_W = 2
) (
    input  logic             rst,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    input  logic [DW-1:0]    rf_data,
    input  logic [CNT_W-1:0] rf_cnt,
    input  logic [NW-1:0]    wen,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    output logic [DW-1:0]    rdata,
    output logic             rbusy
);
    import ysyx_23060201_pkg::X0;

    logic          hit;
    logic [DW-1:0] byp;

    // Later ports overwrite earlier ones so the highest write port wins the bypass.
    always_comb begin
        hit = 1'b0;
        byp = rf_data;
        for (int j = 0; j < NW; j++) begin
            if (wen[j] && waddr[j*AW +: AW] == raddr) begin
                hit = 1'b1;
                byp = wdata[j*DW +: DW];
            end
        end
    end

    // A bypassed operand is complete by definition, so it never reports busy.
    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (!rst && ren && raddr != X0) begin
            rdata = byp;
            rbusy = !hit && (rf_cnt != '0);
        end
    end

endmodule

// File: rtl/ysyx_23060201_gpr_scoreboard.sv
// GPR file with NR bypassed read ports, NW write-back ports and a per-register
// pending counter so decode can stall on operands still in flight.
module ysyx_23060201_gpr_scoreboard #(
    parameter int GPR_ADDR_WIDTH = ysyx_23060201_pkg::GPR_ADDR_WIDTH,
    parameter int DATA_WIDTH     = ysyx_23060201_pkg::DATA_WIDTH,
    parameter int NR             = 2,
    parameter int NW             = 2,
    parameter int CNT_W          = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NR-1:0]                gpr_ren,
    input  logic [NR*GPR_ADDR_WIDTH-1:0] gpr_raddr,
    output logic [NR*DATA_WIDTH-1:0]     gpr_rdata,
    output logic [NR-1:0]                gpr_rbusy,
    input  logic [NW-1:0]                gpr_wen,
    input  logic [NW*GPR_ADDR_WIDTH-1:0] gpr_waddr,
    input  logic [NW*DATA_WIDTH-1:0]     gpr_wdata,
    input  logic                         iss_valid,
    input  logic [GPR_ADDR_WIDTH-1:0]    iss_rd,
    output logic                         iss_ready,
    output logic                         stall,
    output logic                         sb_err
);
    import ysyx_23060201_pkg::X0;

    localparam int AW   = GPR_ADDR_WIDTH;
    localparam int DW   = DATA_WIDTH;
    localparam int NREG = 1 << AW;
    // Wide enough for cnt + 1 and for the count of write-backs without wrapping.
    localparam int SW   = CNT_W + $clog2(NW + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DW-1:0]    regs    [NREG];
    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [SW-1:0]    dec     [NREG];
    logic [SW-1:0]    sum     [NREG];
    logic             err_set;
    logic             iss_fire;

    assign iss_ready = !rst && (iss_rd == X0 || cnt[iss_rd] != CNT_MAX);
    assign iss_fire  = iss_valid && iss_ready;

    // x0 never increments, so any write-back to it underflows and flags sb_err.
    always_comb begin
        err_set = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            dec[r] = '0;
            for (int j = 0; j < NW; j++) begin
                if (gpr_wen[j] && gpr_waddr[j*AW +: AW] == AW'(r))
                    dec[r] = dec[r] + SW'(1);
            end
            sum[r] = SW'(cnt[r]) + SW'(iss_fire && iss_rd == AW'(r) && iss_rd != X0);
            if (sum[r] < dec[r]) begin
                cnt_nxt[r] = '0;
                err_set    = 1'b1;
            end else begin
                cnt_nxt[r] = CNT_W'(sum[r] - dec[r]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (gpr_wen[j] && gpr_waddr[j*AW +: AW] != X0)
                    regs[gpr_waddr[j*AW +: AW]] <= gpr_wdata[j*DW +: DW];
            end
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_nxt[r];
            if (err_set)
                sb_err <= 1'b1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NR; i++) begin : g_rport
            ysyx_23060201_gpr_rport #(
                .AW   (AW),
                .DW   (DW),
                .NW   (NW),
                .CNT_W(CNT_W)
            ) u_rport (
                .rst    (rst),
                .ren    (gpr_ren[i]),
                .raddr  (gpr_raddr[i*AW +: AW]),
                .rf_data(regs[gpr_raddr[i*AW +: AW]]),
                .rf_cnt (cnt[gpr_raddr[i*AW +: AW]]),
                .wen    (gpr_wen),
                .waddr  (gpr_waddr),
                .wdata  (gpr_wdata),
                .rdata  (gpr_rdata[i*DW +: DW]),
                .rbusy  (gpr_rbusy[i])
            );
        end
    endgenerate

    assign stall = |gpr_rbusy;

endmodule

// File: tb/tb_ysyx_23060201_gpr_scoreboard.sv
// Scenario bench for the GPR scoreboard: expectations queued at drive time, popped at sample.
module tb_ysyx_23060201_gpr_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ren;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic        stall;
    logic        sb_err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    always #5 clk = ~clk;

    ysyx_23060201_gpr_scoreboard dut (
        .clk      (clk),
        .rst      (rst),
        .gpr_ren  (ren),
        .gpr_raddr(raddr),
        .gpr_rdata(rdata),
        .gpr_rbusy(rbusy),
        .gpr_wen  (wen),
        .gpr_waddr(waddr),
        .gpr_wdata(wdata),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .iss_ready(iss_ready),
        .stall    (stall),
        .sb_err   (sb_err)
    );

    task automatic idle();
        ren = '0; raddr = '0; wen = '0; waddr = '0; wdata = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        ren[p] = 1'b1; raddr[p*5 +: 5] = a;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wen[p] = 1'b1; waddr[p*5 +: 5] = a; wdata[p*32 +: 32] = d;
    endtask

    task automatic iss(input logic [4:0] a);
        iss_valid = 1'b1; iss_rd = a;
    endtask

    // Commit the current cycle's stimulus and clear inputs for the next one.
    task automatic tick();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; rd(0, 5); rd(1, 5);
        @(posedge clk); #1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[31:0] !== e) begin miscompares++; $display("FAIL rst_rdata0 got=%h exp=%h", rdata[31:0], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(iss_ready) !== e) begin miscompares++; $display("FAIL rst_iss_ready got=%h exp=%h", iss_ready, e); end
        @(posedge clk); #1 rst = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[31:0] !== e) begin miscompares++; $display("FAIL x5_p0 got=%h exp=%h", rdata[31:0], e); end
        e = exp_q.pop_front(); vectors++;
        if (rdata[63:32] !== e) begin miscompares++; $display("FAIL x5_p1 got=%h exp=%h", rdata[63:32], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(rbusy) !== e) begin miscompares++; $display("FAIL x5_busy got=%h exp=%h", rbusy, e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(sb_err) !== e) begin miscompares++; $display("FAIL rst_sb_err got=%h exp=%h", sb_err, e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(iss_ready) !== e) begin miscompares++; $display("FAIL post_rst_ready got=%h exp=%h", iss_ready, e); end
    endtask

    task automatic test_write_read();
        idle(); wr(0, 3, 32'hDEADBEEF); wr(1, 0, 32'h1234); rd(1, 0);
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[63:32] !== e) begin miscompares++; $display("FAIL x0_nobyp got=%h exp=%h", rdata[63:32], e); end
        tick();
        rd(0, 3); rd(1, 0);
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[31:0] !== e) begin miscompares++; $display("FAIL x3_read got=%h exp=%h", rdata[31:0], e); end
        e = exp_q.pop_front(); vectors++;
        if (rdata[63:32] !== e) begin miscompares++; $display("FAIL x0_read got=%h exp=%h", rdata[63:32], e); end
        tick();
        raddr[4:0] = 5'd3;
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[31:0] !== e) begin miscompares++; $display("FAIL ren_off got=%h exp=%h", rdata[31:0], e); end
        tick();
    endtask

    task automatic test_bypass();
        wr(0, 7, 32'hA5A5A5A5); rd(0, 7);
        exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[31:0] !== e) begin miscompares++; $display("FAIL byp_x7 got=%h exp=%h", rdata[31:0], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(rbusy[0]) !== e) begin miscompares++; $display("FAIL byp_x7_busy got=%h exp=%h", rbusy[0], e); end
        tick();
        wr(0, 7, 32'h1); wr(1, 7, 32'h2); rd(0, 7); rd(1, 7);
        exp_q.push_back(32'h2); exp_q.push_back(32'h2);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[31:0] !== e) begin miscompares++; $display("FAIL byp_prio_p0 got=%h exp=%h", rdata[31:0], e); end
        e = exp_q.pop_front(); vectors++;
        if (rdata[63:32] !== e) begin miscompares++; $display("FAIL byp_prio_p1 got=%h exp=%h", rdata[63:32], e); end
        tick();
        rd(0, 7);
        exp_q.push_back(32'h2);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[31:0] !== e) begin miscompares++; $display("FAIL store_prio got=%h exp=%h", rdata[31:0], e); end
        tick();
    endtask

    task automatic test_scoreboard();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            iss(9);
            exp_q.push_back(32'h1);
            @(negedge clk);
            e = exp_q.pop_front(); vectors++;
            if (32'(iss_ready) !== e) begin miscompares++; $display("FAIL iss9_ready_%0d got=%h exp=%h", k, iss_ready, e); end
            tick();
        end
        iss(9); rd(0, 9);
        exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(iss_ready) !== e) begin miscompares++; $display("FAIL iss9_full got=%h exp=%h", iss_ready, e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(rbusy[0]) !== e) begin miscompares++; $display("FAIL x9_busy got=%h exp=%h", rbusy[0], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(stall) !== e) begin miscompares++; $display("FAIL x9_stall got=%h exp=%h", stall, e); end
        tick();
        wr(0, 9, 32'h11); wr(1, 9, 32'h22); rd(0, 9);
        exp_q.push_back(32'h22); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[31:0] !== e) begin miscompares++; $display("FAIL x9_dual_wb got=%h exp=%h", rdata[31:0], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(stall) !== e) begin miscompares++; $display("FAIL x9_dual_stall got=%h exp=%h", stall, e); end
        tick();
        rd(0, 9); iss_rd = 5'd9;
        exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(rbusy[0]) !== e) begin miscompares++; $display("FAIL x9_cnt1_busy got=%h exp=%h", rbusy[0], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(iss_ready) !== e) begin miscompares++; $display("FAIL x9_cnt1_ready got=%h exp=%h", iss_ready, e); end
        tick();
        wr(0, 9, 32'h33); rd(1, 9);
        exp_q.push_back(32'h33); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[63:32] !== e) begin miscompares++; $display("FAIL x9_last_byp got=%h exp=%h", rdata[63:32], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(rbusy[1]) !== e) begin miscompares++; $display("FAIL x9_last_busy got=%h exp=%h", rbusy[1], e); end
        tick();
        rd(0, 9);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(rbusy[0]) !== e) begin miscompares++; $display("FAIL x9_drained got=%h exp=%h", rbusy[0], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(sb_err) !== e) begin miscompares++; $display("FAIL x9_sb_err got=%h exp=%h", sb_err, e); end
        tick();
    endtask

    task automatic test_same_cycle();
        do_reset();
        iss(4); tick();
        iss(4); wr(0, 4, 32'h44); rd(0, 4);
        exp_q.push_back(32'h44); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[31:0] !== e) begin miscompares++; $display("FAIL x4_iss_wb_data got=%h exp=%h", rdata[31:0], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(rbusy[0]) !== e) begin miscompares++; $display("FAIL x4_iss_wb_busy got=%h exp=%h", rbusy[0], e); end
        tick();
        rd(0, 4);
        exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(rbusy[0]) !== e) begin miscompares++; $display("FAIL x4_net_busy got=%h exp=%h", rbusy[0], e); end
        tick();
        rd(0, 8); iss(8);
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(rbusy[0]) !== e) begin miscompares++; $display("FAIL x8_read_first got=%h exp=%h", rbusy[0], e); end
        tick();
        rd(0, 8);
        exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(rbusy[0]) !== e) begin miscompares++; $display("FAIL x8_after_iss got=%h exp=%h", rbusy[0], e); end
        tick();
        wr(0, 4, 32'h45); wr(1, 8, 32'h88); tick();
        rd(0, 4);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(rbusy[0]) !== e) begin miscompares++; $display("FAIL x4_drained got=%h exp=%h", rbusy[0], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(sb_err) !== e) begin miscompares++; $display("FAIL sb_err_clean got=%h exp=%h", sb_err, e); end
        tick();
        wr(0, 6, 32'h66); tick();
        exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(sb_err) !== e) begin miscompares++; $display("FAIL sb_err_set got=%h exp=%h", sb_err, e); end
        repeat (3) tick();
        exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(sb_err) !== e) begin miscompares++; $display("FAIL sb_err_sticky got=%h exp=%h", sb_err, e); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        repeat (3) begin iss(2); tick(); end
        wr(0, 2, 32'h55); tick();
        rd(0, 2);
        exp_q.push_back(32'h55); exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[31:0] !== e) begin miscompares++; $display("FAIL x2_pre_data got=%h exp=%h", rdata[31:0], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(rbusy[0]) !== e) begin miscompares++; $display("FAIL x2_pre_busy got=%h exp=%h", rbusy[0], e); end
        tick();
        rst = 1'b1; rd(0, 2);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[31:0] !== e) begin miscompares++; $display("FAIL rst_force_data got=%h exp=%h", rdata[31:0], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(stall) !== e) begin miscompares++; $display("FAIL rst_force_stall got=%h exp=%h", stall, e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(iss_ready) !== e) begin miscompares++; $display("FAIL rst_force_ready got=%h exp=%h", iss_ready, e); end
        @(posedge clk); #1 rst = 1'b0;
        rd(0, 2); iss_rd = 5'd2;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (rdata[31:0] !== e) begin miscompares++; $display("FAIL x2_post_data got=%h exp=%h", rdata[31:0], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(rbusy[0]) !== e) begin miscompares++; $display("FAIL x2_post_busy got=%h exp=%h", rbusy[0], e); end
        e = exp_q.pop_front(); vectors++;
        if (32'(iss_ready) !== e) begin miscompares++; $display("FAIL x2_post_ready got=%h exp=%h", iss_ready, e); end
        tick();
        wr(0, 2, 32'h77); tick();
        exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(sb_err) !== e) begin miscompares++; $display("FAIL stale_wb_err got=%h exp=%h", sb_err, e); end
        tick();
    endtask

    initial begin
        idle(); rst = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_same_cycle();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
